add_seq: RTL and testbench

Multi-byte add sequencer that shares one external 8-bit adder (`_GGADD8`-style: A, B, CI in, S, CO out, purely combinational) to compute NBYTES-wide sums one byte per clock, least-significant byte first. It sits between a requester issuing wide add operations and the byte-wide adder datapath. It owns operand latching, byte indexing and the carry chain, and presents a START/BUSY/DONE handshake upstream.

---
 rtl/add_seq.sv | 133 +++++++++++++
 tb/tb_add_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq.sv
// Multi-byte add sequencer driving one shared external 8-bit combinational adder, LSB first.
// Latency: START at edge 0, BUSY in cycles 1..NBYTES, DONE pulse in cycle NBYTES+1.
// Backpressure: none; START is ignored while BUSY and accepted in IDLE or in the DONE cycle.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   START, A, B, CI   request and operands, latched when START is accepted
//   SUB               (only with ADDSEQ_SUB_EN) latch ~B and force carry-in to 1 for A-B
//   BUSY, DONE        status: BUSY while bytes are processed, DONE one-cycle completion pulse
//   S, CO             result and final carry, held until the next completion
//   AA, AB, ACI       byte operands and carry presented to the external adder (0 outside RUN)
//   AS, ACO           sum byte and carry returned by the external adder
// Optional feature macro: ADDSEQ_SUB_EN.
module add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [8*NBYTES-1:0]   A,
    input  logic [8*NBYTES-1:0]   B,
    input  logic                  CI,
`ifdef ADDSEQ_SUB_EN
    input  logic                  SUB,
`endif
    output logic                  BUSY,
    output logic                  DONE,
    output logic [8*NBYTES-1:0]   S,
    output logic                  CO,
    output logic [7:0]            AA,
    output logic [7:0]            AB,
    output logic                  ACI,
    input  logic [7:0]            AS,
    input  logic                  ACO
);

    localparam int W     = 8 * NBYTES;
    // Keep the index at least one bit wide so NBYTES=1 still elaborates.
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       acc_q;
    logic [W-1:0]       acc_nxt;
    logic [W-1:0]       s_q;
    logic               co_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               run;
    logic               accept;
    logic               last;
    logic [W-1:0]       b_in;
    logic               carry_in;

    assign run    = (state_q == ST_RUN);
    assign accept = START && (state_q != ST_RUN);
    assign last   = (idx_q == IDX_W'(NBYTES - 1));

`ifdef ADDSEQ_SUB_EN
    // Subtraction as A + ~B + 1; CO=1 then means "no borrow".
    assign b_in     = SUB ? ~B : B;
    assign carry_in = SUB | CI;
`else
    assign b_in     = B;
    assign carry_in = CI;
`endif

    // Accumulator with the current adder byte merged in, so the final byte
    // is already part of the value loaded into S on the last RUN edge.
    always_comb begin
        acc_nxt              = acc_q;
        acc_nxt[8*idx_q +: 8] = AS;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last)   state_d = ST_FIN;
            ST_FIN:  state_d = START ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= A;
                b_q     <= b_in;
                carry_q <= carry_in;
                idx_q   <= '0;
                acc_q   <= '0;
            end else if (run) begin
                acc_q   <= acc_nxt;
                carry_q <= ACO;
                idx_q   <= idx_q + IDX_W'(1);
                if (last) begin
                    s_q  <= acc_nxt;
                    co_q <= ACO;
                end
            end
        end
    end

    // Adder-side outputs come only from registers and are forced to 0 outside RUN.
    assign AA   = run ? a_q[8*idx_q +: 8] : 8'd0;
    assign AB   = run ? b_q[8*idx_q +: 8] : 8'd0;
    assign ACI  = run ? carry_q : 1'b0;

    assign BUSY = run;
    assign DONE = (state_q == ST_FIN);
    assign S    = s_q;
    assign CO   = co_q;

endmodule

// File: tb/tb_add_seq.sv
// Bench for add_seq: NBYTES=4 main instance plus an NBYTES=1 instance, each with a behavioural 8-bit adder.
// Latency: checks BUSY/DONE timing cycle by cycle against the START edge.
// Backpressure: exercises START during RUN (ignored) and START held through DONE (back-to-back).
module tb_add_seq;

    localparam int NB = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic [31:0]   A;
    logic [31:0]   B;
    logic          CI;
`ifdef ADDSEQ_SUB_EN
    logic          SUB;
`endif
    logic          BUSY;
    logic          DONE;
    logic [31:0]   S;
    logic          CO;
    logic [7:0]    AA;
    logic [7:0]    AB;
    logic          ACI;
    logic [7:0]    AS;
    logic          ACO;

    logic          c1_start;
    logic [7:0]    c1_a;
    logic [7:0]    c1_b;
    logic          c1_ci;
`ifdef ADDSEQ_SUB_EN
    logic          c1_sub;
`endif
    logic          c1_busy;
    logic          c1_done;
    logic [7:0]    c1_s;
    logic          c1_co;
    logic [7:0]    c1_aa;
    logic [7:0]    c1_ab;
    logic          c1_aci;
    logic [7:0]    c1_as;
    logic          c1_aco;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    // Behavioural external adders.
    assign {ACO, AS}       = 9'(AA) + 9'(AB) + 9'(ACI);
    assign {c1_aco, c1_as} = 9'(c1_aa) + 9'(c1_ab) + 9'(c1_aci);

    add_seq #(.NBYTES(NB)) dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .CI(CI),
`ifdef ADDSEQ_SUB_EN
        .SUB(SUB),
`endif
        .BUSY(BUSY), .DONE(DONE), .S(S), .CO(CO),
        .AA(AA), .AB(AB), .ACI(ACI), .AS(AS), .ACO(ACO)
    );

    add_seq #(.NBYTES(1)) dut1 (
        .CLK(CLK), .RST(RST), .START(c1_start), .A(c1_a), .B(c1_b), .CI(c1_ci),
`ifdef ADDSEQ_SUB_EN
        .SUB(c1_sub),
`endif
        .BUSY(c1_busy), .DONE(c1_done), .S(c1_s), .CO(c1_co),
        .AA(c1_aa), .AB(c1_ab), .ACI(c1_aci), .AS(c1_as), .ACO(c1_aco)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s disagreed", tag);
        end
    endtask

    // Advance one clock; outputs are then sampled on the falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Issue one operation on the 4-byte instance and check every cycle up to DONE.
    // Leaves the bench in the DONE cycle with START low.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub);
        logic [31:0] bb;
        logic        c0;
        logic [32:0] r;
        logic [63:0] mask;
        logic [63:0] partial;
        bb = sub ? ~b : b;
        c0 = sub ? 1'b1 : ci;
        r  = {1'b0, a} + {1'b0, bb} + 33'(c0);
        START = 1'b1; A = a; B = b; CI = ci;
`ifdef ADDSEQ_SUB_EN
        SUB = sub;
`endif
        tick();
        // Scramble inputs: latched operands must be unaffected.
        START = 1'b0; A = $urandom; B = $urandom; CI = 1'($urandom_range(0, 1));
`ifdef ADDSEQ_SUB_EN
        SUB = 1'($urandom_range(0, 1));
`endif
        for (int k = 0; k < NB; k++) begin
            mask    = (64'd1 << (8 * k)) - 64'd1;
            partial = (64'(a) & mask) + (64'(bb) & mask) + 64'(c0);
            chk("busy_run", 64'(BUSY), 64'd1);
            chk("done_run", 64'(DONE), 64'd0);
            chk("aa_byte",  64'(AA), (64'(a)  >> (8 * k)) & 64'hFF);
            chk("ab_byte",  64'(AB), (64'(bb) >> (8 * k)) & 64'hFF);
            chk("aci_byte", 64'(ACI), (partial >> (8 * k)) & 64'd1);
            tick();
        end
        chk("busy_fin", 64'(BUSY), 64'd0);
        chk("done_fin", 64'(DONE), 64'd1);
        chk("sum",      64'(S),    64'(r[31:0]));
        chk("carry",    64'(CO),   64'(r[32]));
        chk("aa_fin",   64'(AA),   64'd0);
    endtask

    initial begin
        logic [32:0] r;
        logic [8:0]  r1;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        z;
        int          gap;

        RST = 1'b1; START = 1'b0; A = '0; B = '0; CI = 1'b0;
        c1_start = 1'b0; c1_a = '0; c1_b = '0; c1_ci = 1'b0;
`ifdef ADDSEQ_SUB_EN
        SUB = 1'b0; c1_sub = 1'b0;
`endif
        tick();
        tick();
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_s",    64'(S),    64'd0);
        chk("rst_co",   64'(CO),   64'd0);
        chk("rst_aa",   64'(AA),   64'd0);
        chk("rst_ab",   64'(AB),   64'd0);
        chk("rst_aci",  64'(ACI),  64'd0);
        RST = 1'b0;
        tick();

        // Byte carry into the second byte.
        do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        tick();
        chk("done_pulse_once", 64'(DONE), 64'd0);

        // Carry ripples through all bytes (ACI=1 in every RUN cycle via the model).
        do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        tick();

        // START during RUN is ignored; exactly one DONE, in cycle 5.
        START = 1'b1; A = 32'd1; B = 32'd1; CI = 1'b0;
        tick();
        START = 1'b0;
        tick();
        START = 1'b1; A = 32'h10; B = 32'h10;
        for (int c = 2; c <= 12; c++) begin
            if (c == 3) START = 1'b0;
            if (c >= 3) chk("ignore_done", 64'(DONE), (c == 5) ? 64'd1 : 64'd0);
            if (c == 5) chk("ignore_sum", 64'(S), 64'd2);
            tick();
        end

        // Reset in the middle of RUN abandons the operation.
        START = 1'b1; A = 32'd5; B = 32'd6; CI = 1'b0;
        tick();
        START = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_busy", 64'(BUSY), 64'd0);
        chk("mid_rst_done", 64'(DONE), 64'd0);
        chk("mid_rst_s",    64'(S),    64'd0);
        chk("mid_rst_co",   64'(CO),   64'd0);
        chk("mid_rst_aa",   64'(AA),   64'd0);
        chk("mid_rst_ab",   64'(AB),   64'd0);
        chk("mid_rst_aci",  64'(ACI),  64'd0);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("mid_rst_no_done", 64'(DONE), 64'd0);
        end
        do_op(32'd3, 32'd4, 1'b0, 1'b0);
        tick();

        // START held high: back-to-back operations, DONE in cycles 5 and 10.
        START = 1'b1; A = 32'd1; B = 32'd2; CI = 1'b0;
        tick();
        A = 32'h80000000; B = 32'h80000000;
        for (int c = 1; c <= 4; c++) begin
            chk("b2b_busy1", 64'(BUSY), 64'd1);
            tick();
        end
        chk("b2b_done1", 64'(DONE), 64'd1);
        chk("b2b_s1",    64'(S),    64'd3);
        chk("b2b_co1",   64'(CO),   64'd0);
        tick();
        for (int c = 6; c <= 9; c++) begin
            chk("b2b_busy2", 64'(BUSY), 64'd1);
            chk("b2b_hold",  64'(S),    64'd3);
            chk("b2b_nodone", 64'(DONE), 64'd0);
            tick();
        end
        chk("b2b_done2", 64'(DONE), 64'd1);
        chk("b2b_s2",    64'(S),    64'd0);
        chk("b2b_co2",   64'(CO),   64'd1);
        START = 1'b0;
        tick();
        chk("b2b_idle", 64'(BUSY | DONE), 64'd0);

`ifdef ADDSEQ_SUB_EN
        do_op(32'd5, 32'd7, 1'b0, 1'b1);
        tick();
        do_op(32'd7, 32'd5, 1'b1, 1'b1);
        tick();
`endif

        // Randomized operations with random idle gaps (gap 0 restarts from DONE).
        for (int n = 0; n < 24; n++) begin
`ifdef ADDSEQ_SUB_EN
            z = 1'($urandom_range(0, 1));
`else
            z = 1'b0;
`endif
            do_op($urandom, $urandom, 1'($urandom_range(0, 1)), z);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("rand_gap_done", 64'(DONE), 64'd0);
            end
        end
        tick();

        // Single-byte instance: RUN is exactly one cycle.
        for (int n = 0; n < 8; n++) begin
            x = 8'($urandom); y = 8'($urandom); z = 1'($urandom_range(0, 1));
            if (n == 0) begin x = 8'hFF; y = 8'h00; z = 1'b1; end
            r1 = 9'(x) + 9'(y) + 9'(z);
            c1_start = 1'b1; c1_a = x; c1_b = y; c1_ci = z;
            tick();
            c1_start = 1'b0; c1_a = 8'($urandom); c1_b = 8'($urandom);
            chk("nb1_busy", 64'(c1_busy), 64'd1);
            chk("nb1_aa",   64'(c1_aa),   64'(x));
            tick();
            chk("nb1_busy_fin", 64'(c1_busy), 64'd0);
            chk("nb1_done", 64'(c1_done), 64'd1);
            chk("nb1_sum",  64'(c1_s),    64'(r1[7:0]));
            chk("nb1_co",   64'(c1_co),   64'(r1[8]));
            tick();
            chk("nb1_done_once", 64'(c1_done), 64'd0);
        end

        // Final result still held on the main instance after idling.
        r = {1'b0, 32'h12345678} + {1'b0, 32'hF0000000};
        do_op(32'h12345678, 32'hF0000000, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) tick();
        chk("hold_s",  64'(S),  64'(r[31:0]));
        chk("hold_co", 64'(CO), 64'(r[32]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
